// File: rtl/axi_mm_pkg.sv
// Shared AXI4 burst types, response codes and the beat-to-beat word index step used by the slave and the BFMs.
// Pure declarations: no latency, no flow control.
package axi_mm_pkg;

  typedef enum logic [1:0] {
    FIXED = 2'b00,
    INCR  = 2'b01,
    WRAP  = 2'b10,
    RSVD  = 2'b11
  } burst_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // Word-index step; WRAP keeps the upper bits and wraps the low bits inside a (len+1)-word window.
  function automatic logic [63:0] next_addr(input logic [63:0] addr, input logic [63:0] len,
                                            input burst_t burst);
    case (burst)
      FIXED:   next_addr = addr;
      WRAP:    next_addr = (addr & ~len) | ((addr + 64'd1) & len);
      default: next_addr = addr + 64'd1;
    endcase
  endfunction

endpackage

// File: rtl/axi_mm_burst_addr.sv
// Burst word-index generator: load start/len/burst, step on advance; LOOKAHEAD=1 presents the index for the
// beat being fetched this cycle (combinational through load/advance), LOOKAHEAD=0 the registered current beat.
module axi_mm_burst_addr
  import axi_mm_pkg::*;
#(
  parameter int IW        = 30,
  parameter int LSIZE     = 8,
  parameter int DEPTH     = 1024,
  parameter bit LOOKAHEAD = 1'b0
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             load,
  input  logic [IW-1:0]    start,
  input  logic [LSIZE-1:0] len,
  input  logic [1:0]       burst,
  input  logic             advance,
  output logic [IW-1:0]    idx,
  output logic             last,
  output logic             oor
);

  localparam logic [63:0] DEPTH_W = 64'(DEPTH);

  logic [IW-1:0]    idx_q, f_idx;
  logic [LSIZE-1:0] cnt_q, len_q, f_cnt, f_len;
  logic [1:0]       burst_q;
  logic [63:0]      nxt;

  always_comb begin
    nxt   = next_addr(64'(idx_q), 64'(len_q), burst_t'(burst_q));
    f_idx = idx_q;
    f_cnt = cnt_q;
    f_len = len_q;
    if (load) begin
      f_idx = start;
      f_cnt = '0;
      f_len = len;
    end else if (advance) begin
      f_idx = nxt[IW-1:0];
      f_cnt = cnt_q + 1'b1;
    end
  end

  assign idx  = LOOKAHEAD ? f_idx : idx_q;
  assign last = LOOKAHEAD ? (f_cnt == f_len) : (cnt_q == len_q);
  assign oor  = 64'(idx) >= DEPTH_W;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      idx_q   <= '0;
      cnt_q   <= '0;
      len_q   <= '0;
      burst_q <= 2'b00;
    end else if (load || advance) begin
      idx_q <= f_idx;
      cnt_q <= f_cnt;
      len_q <= f_len;
      if (load) burst_q <= burst;
    end
  end

endmodule

// File: rtl/axi_mm_slave_mem.sv
// AXI4 slave over an on-chip word array; one burst per direction, first R beat 1 cycle after AR, back-to-back beats
// while rready holds, R/B outputs held under backpressure. AXI_MEM_OOR_ERR_EN: out-of-range beats give DECERR.
module axi_mm_slave_mem
  import axi_mm_pkg::*;
#(
  parameter int ASIZE  = 32,
  parameter int DSIZE  = 32,
  parameter int LSIZE  = 8,
  parameter int IDSIZE = 4,
  parameter int DEPTH  = 1024
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic [IDSIZE-1:0] s_awid,
  input  logic [ASIZE-1:0]  s_awaddr,
  input  logic [LSIZE-1:0]  s_awlen,
  input  logic [1:0]        s_awburst,
  input  logic              s_awvalid,
  output logic              s_awready,
  input  logic [DSIZE-1:0]  s_wdata,
  input  logic [DSIZE/8-1:0] s_wstrb,
  input  logic              s_wlast,
  input  logic              s_wvalid,
  output logic              s_wready,
  output logic [IDSIZE-1:0] s_bid,
  output logic [1:0]        s_bresp,
  output logic              s_bvalid,
  input  logic              s_bready,
  input  logic [IDSIZE-1:0] s_arid,
  input  logic [ASIZE-1:0]  s_araddr,
  input  logic [LSIZE-1:0]  s_arlen,
  input  logic [1:0]        s_arburst,
  input  logic              s_arvalid,
  output logic              s_arready,
  output logic [IDSIZE-1:0] s_rid,
  output logic [DSIZE-1:0]  s_rdata,
  output logic [1:0]        s_rresp,
  output logic              s_rlast,
  output logic              s_rvalid,
  input  logic              s_rready
);

  localparam int OFF = $clog2(DSIZE / 8);
  localparam int IW  = ASIZE - OFF;
  localparam int MW  = $clog2(DEPTH);
  localparam int NB  = DSIZE / 8;
`ifdef AXI_MEM_OOR_ERR_EN
  localparam bit OOR_EN = 1'b1;
`else
  localparam bit OOR_EN = 1'b0;
`endif

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
  typedef enum logic {R_IDLE, R_DATA} rstate_t;

  wstate_t          wst;
  rstate_t          rst_q;
  logic [DSIZE-1:0] mem [DEPTH];

  generate
    if (OFF > 0) begin : g_lsb
      logic unused_lsb;
      assign unused_lsb = ^{s_awaddr[OFF-1:0], s_araddr[OFF-1:0]};
    end
  endgenerate

  // ---------------- write path ----------------
  logic          aw_hs, w_hs, w_last, w_oor, w_bad, w_slv, w_dec, w_slv_n, w_dec_n;
  logic [IW-1:0] w_idx;

  assign aw_hs   = s_awvalid & s_awready;
  assign w_hs    = s_wvalid & s_wready;
  assign w_bad   = OOR_EN & w_oor;
  assign w_slv_n = w_slv | (s_wlast != w_last);
  assign w_dec_n = w_dec | w_bad;

  axi_mm_burst_addr #(.IW(IW), .LSIZE(LSIZE), .DEPTH(DEPTH), .LOOKAHEAD(1'b0)) u_wgen (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .load(aw_hs), .start(s_awaddr[ASIZE-1:OFF]),
    .len(s_awlen), .burst(s_awburst), .advance(w_hs), .idx(w_idx), .last(w_last), .oor(w_oor)
  );

  always_ff @(posedge sys_clk) begin
    if (w_hs && !w_bad)
      for (int b = 0; b < NB; b++)
        if (s_wstrb[b]) mem[w_idx[MW-1:0]][8*b +: 8] <= s_wdata[8*b +: 8];
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      wst       <= W_IDLE;
      s_awready <= 1'b1;
      s_wready  <= 1'b0;
      s_bvalid  <= 1'b0;
      s_bresp   <= RESP_OKAY;
      s_bid     <= '0;
      w_slv     <= 1'b0;
      w_dec     <= 1'b0;
    end else begin
      case (wst)
        W_IDLE: if (s_awvalid) begin
          s_awready <= 1'b0;
          s_wready  <= 1'b1;
          s_bid     <= s_awid;
          w_slv     <= (burst_t'(s_awburst) == RSVD);
          w_dec     <= 1'b0;
          wst       <= W_DATA;
        end
        // Burst length comes from the beat counter; a wlast disagreement only flags SLVERR.
        W_DATA: if (s_wvalid) begin
          w_slv <= w_slv_n;
          w_dec <= w_dec_n;
          if (w_last) begin
            s_wready <= 1'b0;
            s_bvalid <= 1'b1;
            s_bresp  <= w_dec_n ? RESP_DECERR : (w_slv_n ? RESP_SLVERR : RESP_OKAY);
            wst      <= W_RESP;
          end
        end
        W_RESP: if (s_bready) begin
          s_bvalid  <= 1'b0;
          s_awready <= 1'b1;
          wst       <= W_IDLE;
        end
        default: wst <= W_IDLE;
      endcase
    end
  end

  // ---------------- read path ----------------
  logic             ar_hs, r_adv, r_last, r_oor, r_bad, r_slv, r_slv_n;
  logic [IW-1:0]    r_idx;
  logic [DSIZE-1:0] r_word;
  logic [1:0]       r_resp_n;

  assign ar_hs    = s_arvalid & s_arready;
  assign r_adv    = (rst_q == R_DATA) & s_rready & ~s_rlast;
  assign r_bad    = OOR_EN & r_oor;
  assign r_slv_n  = ar_hs ? (burst_t'(s_arburst) == RSVD) : r_slv;
  assign r_resp_n = r_bad ? RESP_DECERR : (r_slv_n ? RESP_SLVERR : RESP_OKAY);
  assign r_word   = r_bad ? '0 : mem[r_idx[MW-1:0]];

  axi_mm_burst_addr #(.IW(IW), .LSIZE(LSIZE), .DEPTH(DEPTH), .LOOKAHEAD(1'b1)) u_rgen (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .load(ar_hs), .start(s_araddr[ASIZE-1:OFF]),
    .len(s_arlen), .burst(s_arburst), .advance(r_adv), .idx(r_idx), .last(r_last), .oor(r_oor)
  );

  // The registered array read gives read-before-write on a same-cycle collision.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      rst_q     <= R_IDLE;
      s_arready <= 1'b1;
      s_rvalid  <= 1'b0;
      s_rlast   <= 1'b0;
      s_rresp   <= RESP_OKAY;
      s_rid     <= '0;
      s_rdata   <= '0;
      r_slv     <= 1'b0;
    end else begin
      case (rst_q)
        R_IDLE: if (s_arvalid) begin
          s_arready <= 1'b0;
          s_rvalid  <= 1'b1;
          s_rid     <= s_arid;
          s_rdata   <= r_word;
          s_rlast   <= r_last;
          s_rresp   <= r_resp_n;
          r_slv     <= r_slv_n;
          rst_q     <= R_DATA;
        end
        R_DATA: if (s_rready) begin
          if (s_rlast) begin
            s_rvalid  <= 1'b0;
            s_rlast   <= 1'b0;
            s_arready <= 1'b1;
            rst_q     <= R_IDLE;
          end else begin
            s_rdata <= r_word;
            s_rlast <= r_last;
            s_rresp <= r_resp_n;
          end
        end
        default: rst_q <= R_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_mm_slave_mem.sv
// Directed bench for axi_mm_slave_mem: expected B/R responses queued at issue, checked by an independent monitor.
module tb_axi_mm_slave_mem;
  import axi_mm_pkg::*;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic [3:0]  s_awid, s_arid, s_bid, s_rid;
  logic [31:0] s_awaddr, s_araddr, s_wdata, s_rdata;
  logic [7:0]  s_awlen, s_arlen;
  logic [1:0]  s_awburst, s_arburst, s_bresp, s_rresp;
  logic [3:0]  s_wstrb;
  logic        s_awvalid, s_awready, s_wlast, s_wvalid, s_wready, s_bvalid, s_bready;
  logic        s_arvalid, s_arready, s_rlast, s_rvalid, s_rready;

  axi_mm_slave_mem dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .s_awid(s_awid), .s_awaddr(s_awaddr), .s_awlen(s_awlen), .s_awburst(s_awburst),
    .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bid(s_bid), .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .s_arid(s_arid), .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arburst(s_arburst),
    .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rid(s_rid), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast),
    .s_rvalid(s_rvalid), .s_rready(s_rready)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct { logic [3:0] id; logic [1:0] resp; } b_exp_t;
  typedef struct { logic [3:0] id; logic [31:0] data; logic [1:0] resp; logic last; } r_exp_t;

  b_exp_t      bq[$];
  r_exp_t      rq[$];
  logic [31:0] wd[$];
  logic [31:0] rx[$];
  int          n_cmp = 0;
  int          n_err = 0;
  bit          rand_rr = 1'b0;
  bit          stalled = 1'b0;
  logic [31:0] held_d;
  logic        held_l;
  b_exp_t      be;
  r_exp_t      re;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tmo(input string nm);
    n_cmp++;
    n_err++;
    $display("FAIL timeout %s: got no handshake, expected one within budget (t=%0t)", nm, $time);
  endtask

  // rready source: always ready, or a coin toss per cycle while rand_rr is set.
  always @(posedge sys_clk) begin
    #1;
    s_rready = rand_rr ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Monitor: a beat is committed at the next posedge when valid&ready are seen at the negedge.
  always @(negedge sys_clk) begin
    if (!sys_rst) begin
      if (s_bvalid && s_bready) begin
        if (bq.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL b_unexpected: got bresp %0h, expected no response", s_bresp);
        end else begin
          be = bq.pop_front();
          chk("bid", 64'(s_bid), 64'(be.id));
          chk("bresp", 64'(s_bresp), 64'(be.resp));
        end
      end
      if (s_rvalid) begin
        if (stalled) begin
          chk("rdata_hold", 64'(s_rdata), 64'(held_d));
          chk("rlast_hold", 64'(s_rlast), 64'(held_l));
        end
        if (s_rready) begin
          stalled = 1'b0;
          if (rq.size() == 0) begin
            n_cmp++; n_err++;
            $display("FAIL r_unexpected: got rdata %0h, expected no beat", s_rdata);
          end else begin
            re = rq.pop_front();
            chk("r_beat{id,data,resp,last}", {s_rid, s_rdata, s_rresp, s_rlast},
                {re.id, re.data, re.resp, re.last});
          end
        end else begin
          stalled = 1'b1;
          held_d  = s_rdata;
          held_l  = s_rlast;
        end
      end else begin
        stalled = 1'b0;
      end
    end
  end

  task automatic drain(input string nm);
    int t = 0;
    while ((bq.size() != 0 || rq.size() != 0) && t < 2000) begin
      @(negedge sys_clk);
      t++;
    end
    if (t >= 2000) begin
      tmo(nm);
      bq.delete();
      rq.delete();
    end
  endtask

  task automatic axw(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                     input logic [1:0] burst, input logic [3:0] strb, input bit bad_last,
                     input logic [1:0] resp);
    int t;
    bq.push_back('{id: id, resp: resp});
    @(posedge sys_clk); #1;
    s_awid = id; s_awaddr = addr; s_awlen = len; s_awburst = burst; s_awvalid = 1'b1;
    t = 0;
    @(negedge sys_clk);
    while (!s_awready && t < 100) begin @(negedge sys_clk); t++; end
    if (t >= 100) tmo("awready");
    @(posedge sys_clk); #1;
    s_awvalid = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      s_wvalid = 1'b1; s_wdata = wd[i]; s_wstrb = strb;
      s_wlast = (i == int'(len)) ^ bad_last;
      t = 0;
      @(negedge sys_clk);
      while (!s_wready && t < 100) begin @(negedge sys_clk); t++; end
      if (t >= 100) tmo("wready");
      @(posedge sys_clk); #1;
    end
    s_wvalid = 1'b0; s_wlast = 1'b0;
    drain("bresp");
  endtask

  task automatic axr(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                     input logic [1:0] burst, input logic [1:0] resp);
    int t;
    for (int i = 0; i <= int'(len); i++)
      rq.push_back('{id: id, data: rx[i], resp: resp, last: (i == int'(len))});
    @(posedge sys_clk); #1;
    s_arid = id; s_araddr = addr; s_arlen = len; s_arburst = burst; s_arvalid = 1'b1;
    t = 0;
    @(negedge sys_clk);
    while (!s_arready && t < 100) begin @(negedge sys_clk); t++; end
    if (t >= 100) tmo("arready");
    @(posedge sys_clk); #1;
    s_arvalid = 1'b0;
    drain("rdata");
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got no end of test, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    sys_rst = 1'b1;
    s_awvalid = 1'b0; s_wvalid = 1'b0; s_arvalid = 1'b0; s_bready = 1'b1; s_wlast = 1'b0;
    s_awid = '0; s_awaddr = '0; s_awlen = '0; s_awburst = '0;
    s_arid = '0; s_araddr = '0; s_arlen = '0; s_arburst = '0; s_wdata = '0; s_wstrb = '0;
    repeat (3) @(negedge sys_clk);
    chk("rst_awready", 64'(s_awready), 64'd1);
    chk("rst_arready", 64'(s_arready), 64'd1);
    chk("rst_wready", 64'(s_wready), 64'd0);
    chk("rst_bvalid", 64'(s_bvalid), 64'd0);
    chk("rst_rvalid_rlast", 64'({s_rvalid, s_rlast}), 64'd0);
    chk("rst_resp_id_data", {s_bresp, s_rresp, s_bid, s_rid, s_rdata}, 64'd0);
    @(posedge sys_clk); #1;
    sys_rst = 1'b0;

    // INCR 9 beats at byte 100 and read back
    wd = '{32'd0, 32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd100, 32'd101, 32'd901};
    axw(4'h1, 32'd100, 8'd8, INCR, 4'hF, 1'b0, RESP_OKAY);
    rx = wd;
    axr(4'h2, 32'd100, 8'd8, INCR, RESP_OKAY);

    // WRAP 4 beats starting at the top of a 16-byte window
    wd = '{32'hA, 32'hB, 32'hC, 32'hD};
    axw(4'h3, 32'h10, 8'd3, INCR, 4'hF, 1'b0, RESP_OKAY);
    rx = '{32'hD, 32'hA, 32'hB, 32'hC};
    axr(4'h4, 32'h1C, 8'd3, WRAP, RESP_OKAY);

    // FIXED: last beat wins; then byte strobes
    wd = '{32'd1, 32'd2, 32'd3, 32'd4};
    axw(4'h5, 32'h40, 8'd3, FIXED, 4'hF, 1'b0, RESP_OKAY);
    rx = '{32'd4};
    axr(4'h6, 32'h40, 8'd0, INCR, RESP_OKAY);
    wd = '{32'h0};
    axw(4'h5, 32'h40, 8'd0, INCR, 4'hF, 1'b0, RESP_OKAY);
    wd = '{32'hFFFF_FFFF};
    axw(4'h5, 32'h40, 8'd0, INCR, 4'b0011, 1'b0, RESP_OKAY);
    rx = '{32'h0000_FFFF};
    axr(4'h6, 32'h40, 8'd0, INCR, RESP_OKAY);

    // 16-beat read under random rready
    wd.delete(); rx.delete();
    for (int i = 0; i < 16; i++) begin
      wd.push_back(32'h1000 + 32'(i) * 32'h11);
      rx.push_back(32'h1000 + 32'(i) * 32'h11);
    end
    axw(4'h7, 32'h300, 8'd15, INCR, 4'hF, 1'b0, RESP_OKAY);
    rand_rr = 1'b1;
    axr(4'h8, 32'h300, 8'd15, INCR, RESP_OKAY);
    rand_rr = 1'b0;

    // wlast on the wrong beat: SLVERR, data still stored
    wd = '{32'h11, 32'h22};
    axw(4'h9, 32'h600, 8'd1, INCR, 4'hF, 1'b1, RESP_SLVERR);
    rx = wd;
    axr(4'h9, 32'h600, 8'd1, INCR, RESP_OKAY);

    // reserved burst acts as INCR with SLVERR
    wd = '{32'h77, 32'h78};
    axw(4'hA, 32'h700, 8'd1, RSVD, 4'hF, 1'b0, RESP_SLVERR);
    rx = wd;
    axr(4'hA, 32'h700, 8'd1, RSVD, RESP_SLVERR);

    // simultaneous AW and AR
    wd = '{32'hC0, 32'hC1};
    rx = '{32'd0, 32'd1, 32'd2};
    fork
      axw(4'hB, 32'h500, 8'd1, INCR, 4'hF, 1'b0, RESP_OKAY);
      axr(4'hC, 32'd100, 8'd2, INCR, RESP_OKAY);
    join
    rx = '{32'hC0, 32'hC1};
    axr(4'hC, 32'h500, 8'd1, INCR, RESP_OKAY);

    // word DEPTH (byte 0x1000), 2 beats
    wd = '{32'h5A5A_0000, 32'h5A5A_0001};
    axw(4'hD, 32'h0, 8'd1, INCR, 4'hF, 1'b0, RESP_OKAY);
`ifdef AXI_MEM_OOR_ERR_EN
    rx = '{32'h0, 32'h0};
    axr(4'hD, 32'h1000, 8'd1, INCR, RESP_DECERR);
`else
    rx = '{32'h5A5A_0000, 32'h5A5A_0001};
    axr(4'hD, 32'h1000, 8'd1, INCR, RESP_OKAY);
`endif

    // reset after 3 of 8 beats
    @(posedge sys_clk); #1;
    s_awid = 4'hE; s_awaddr = 32'h200; s_awlen = 8'd7; s_awburst = INCR; s_awvalid = 1'b1;
    @(negedge sys_clk);
    chk("mid_awready", 64'(s_awready), 64'd1);
    @(posedge sys_clk); #1;
    s_awvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      s_wvalid = 1'b1; s_wdata = 32'hB0 + 32'(i); s_wstrb = 4'hF; s_wlast = 1'b0;
      @(negedge sys_clk);
      chk("mid_wready", 64'(s_wready), 64'd1);
      @(posedge sys_clk); #1;
    end
    s_wvalid = 1'b0;
    sys_rst = 1'b1;
    @(negedge sys_clk);
    chk("abort_awready", 64'(s_awready), 64'd1);
    chk("abort_wready", 64'(s_wready), 64'd0);
    chk("abort_bvalid", 64'(s_bvalid), 64'd0);
    @(posedge sys_clk); #1;
    sys_rst = 1'b0;
    wd = '{32'hE0, 32'hE1};
    axw(4'h1, 32'h280, 8'd1, INCR, 4'hF, 1'b0, RESP_OKAY);
    rx = '{32'hB0, 32'hB1, 32'hB2};
    axr(4'h2, 32'h200, 8'd2, INCR, RESP_OKAY);
    rx = wd;
    axr(4'h3, 32'h280, 8'd1, INCR, RESP_OKAY);

    repeat (4) @(negedge sys_clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
